// File: rtl/cpu_oci_trace_pkg.sv
// Shared definitions for the CPU OCI trace monitor: state encoding, FIFO
// entry sizing (entry = {last, data}, last in the MSB) and a clog2 helper.
package cpu_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNLOAD = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int entry_w(input int slot_w);
    return slot_w + 1;
  endfunction

endpackage

// File: rtl/cpu_oci_trace_fifo.sv
// Registered synchronous FIFO with exact occupancy; the head is read
// straight from storage, so a push at one edge is visible after that edge.
module cpu_oci_trace_fifo
  import cpu_oci_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   head_o,
  output logic               valid_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [clog2(DEPTH):0] level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A pop never frees room for a push in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = ~empty_o;
  assign level_o = level_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_oci_trace_monitor.sv
// Accepts packed DCT frames, serialises their slots into a FIFO with an
// end-of-frame marker, and runs the test_ending / test_has_ended wind-down.
module cpu_oci_trace_monitor
  import cpu_oci_trace_pkg::*;
#(
  parameter int SLOTS  = 3,
  parameter int SLOT_W = 10,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 4,
  parameter int FRM_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    dct_valid_i,
  output logic                    dct_ready_o,
  input  logic [SLOTS*SLOT_W-1:0] dct_buffer_i,
  input  logic [CNT_W-1:0]        dct_count_i,
  input  logic                    test_ending_i,
  input  logic                    test_has_ended_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SLOT_W-1:0]       out_data_o,
  output logic                    out_last_o,
  output logic [clog2(DEPTH):0]   fifo_level_o,
  output logic [FRM_W-1:0]        frame_count_o,
  output logic                    count_err_o,
  output logic                    trunc_err_o,
  output logic                    done_o,
  output logic [1:0]              state_o
);

  localparam int EW = entry_w(SLOT_W);

  state_t                  state_q, state_d;
  logic [SLOTS*SLOT_W-1:0] buf_q;
  logic [CNT_W-1:0]        k_q, idx_q, k_new;
  logic [FRM_W-1:0]        frame_count_q;
  logic                    count_err_q, trunc_err_q;
  logic                    accept, push, set_trunc, last_slot;
  logic [SLOT_W-1:0]       cur_slot;
  logic                    fifo_full, fifo_empty;
  logic [EW-1:0]           fifo_head;

  assign k_new     = (dct_count_i > CNT_W'(SLOTS)) ? CNT_W'(SLOTS) : dct_count_i;
  assign last_slot = (idx_q == k_q - CNT_W'(1));

  always_comb begin
    cur_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (idx_q == CNT_W'(i)) cur_slot = buf_q[i*SLOT_W +: SLOT_W];
    end
  end

  // Handshakes: a frame transfers on a rising edge where dct_valid_i and
  // dct_ready_o are both high; a slot leaves on out_valid_o & out_ready_i.
  always_comb begin
    state_d     = state_q;
    dct_ready_o = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    set_trunc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dct_ready_o = ~test_ending_i;
        accept      = dct_valid_i & dct_ready_o;
        if (accept) begin
          if (k_new != '0) state_d = ST_UNLOAD;
        end else if (test_ending_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_UNLOAD: begin
        push = ~fifo_full;
        if (push && last_slot) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
    // End of test overrides everything; pending data marks truncation.
    if (test_has_ended_i && state_q != ST_DONE) begin
      state_d   = ST_DONE;
      push      = 1'b0;
      set_trunc = ~fifo_empty | (state_q == ST_UNLOAD);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_q         <= '0;
      k_q           <= '0;
      idx_q         <= '0;
      frame_count_q <= '0;
      count_err_q   <= 1'b0;
      trunc_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        buf_q <= dct_buffer_i;
        k_q   <= k_new;
        idx_q <= '0;
        if (frame_count_q != '1) frame_count_q <= frame_count_q + FRM_W'(1);
        if (dct_count_i > CNT_W'(SLOTS)) count_err_q <= 1'b1;
      end
      if (push) idx_q <= idx_q + CNT_W'(1);
      if (set_trunc) trunc_err_q <= 1'b1;
    end
  end

  cpu_oci_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i ({last_slot, cur_slot}),
    .pop_i       (out_ready_i),
    .head_o      (fifo_head),
    .valid_o     (out_valid_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  assign out_last_o    = fifo_head[EW-1];
  assign out_data_o    = fifo_head[SLOT_W-1:0];
  assign frame_count_o = frame_count_q;
  assign count_err_o   = count_err_q;
  assign trunc_err_o   = trunc_err_q;
  assign done_o        = (state_q == ST_DONE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_cpu_oci_trace_monitor.sv
// Directed + randomized bench for cpu_oci_trace_monitor; a slot-queue model
// fed by accepted frames predicts every slot leaving the FIFO.
module tb_cpu_oci_trace_monitor;

  localparam int SLOTS  = 3;
  localparam int SLOT_W = 10;
  localparam int CNT_W  = 4;
  localparam int FRM_W  = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_UNLOAD = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

  logic                    clk = 1'b0;
  logic                    reset_i;
  logic                    dct_valid_i;
  logic                    dct_ready_o;
  logic [SLOTS*SLOT_W-1:0] dct_buffer_i;
  logic [CNT_W-1:0]        dct_count_i;
  logic                    test_ending_i;
  logic                    test_has_ended_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [SLOT_W-1:0]       out_data_o;
  logic                    out_last_o;
  logic [4:0]              fifo_level_o;
  logic [FRM_W-1:0]        frame_count_o;
  logic                    count_err_o;
  logic                    trunc_err_o;
  logic                    done_o;
  logic [1:0]              state_o;

  logic [SLOT_W:0] exp_q[$];
  logic [SLOT_W:0] mon_e;
  int              mon_k;
  int              n_checks = 0;
  int              n_fail   = 0;
  int              n_pops   = 0;
  logic            rand_rdy = 1'b0;

  cpu_oci_trace_monitor dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .dct_valid_i      (dct_valid_i),
    .dct_ready_o      (dct_ready_o),
    .dct_buffer_i     (dct_buffer_i),
    .dct_count_i      (dct_count_i),
    .test_ending_i    (test_ending_i),
    .test_has_ended_i (test_has_ended_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_data_o       (out_data_o),
    .out_last_o       (out_last_o),
    .fifo_level_o     (fifo_level_o),
    .frame_count_o    (frame_count_o),
    .count_err_o      (count_err_o),
    .trunc_err_o      (trunc_err_o),
    .done_o           (done_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: an accepted frame contributes min(count, SLOTS) slots in order,
  // the final one flagged last; each slot leaving the FIFO must match.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (dct_valid_i && dct_ready_o) begin
        mon_k = (int'(dct_count_i) > SLOTS) ? SLOTS : int'(dct_count_i);
        for (int s = 0; s < mon_k; s++)
          exp_q.push_back({(s == mon_k - 1), dct_buffer_i[s*SLOT_W +: SLOT_W]});
      end
      if (out_valid_o && out_ready_i) begin
        n_pops++;
        if (exp_q.size() != 0) mon_e = exp_q.pop_front();
        else                   mon_e = 'x;
        chk("pop_data", {21'd0, out_last_o, out_data_o}, {21'd0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [SLOTS*SLOT_W-1:0] b, input logic [CNT_W-1:0] c);
    int n;
    n = 0;
    dct_valid_i  = 1'b1;
    dct_buffer_i = b;
    dct_count_i  = c;
    while (!dct_ready_o && n < 200) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(dct_ready_o), 32'd1);
    tick();
    dct_valid_i = 1'b0;
  endtask

  task automatic wait_settle(input string tag);
    int n;
    n = 0;
    while (!(fifo_level_o == 0 && state_o != S_UNLOAD) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(fifo_level_o == 0 && state_o != S_UNLOAD), 32'd1);
  endtask

  task automatic wait_unload_done(input string tag);
    int n;
    n = 0;
    while (state_o == S_UNLOAD && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(state_o), 32'(S_IDLE));
  endtask

  task automatic apply_reset();
    reset_i          = 1'b1;
    dct_valid_i      = 1'b0;
    test_ending_i    = 1'b0;
    test_has_ended_i = 1'b0;
    out_ready_i      = 1'b0;
    rand_rdy         = 1'b0;
    tick();
    tick();
    exp_q.delete();
    reset_i = 1'b0;
  endtask

  initial begin
    int p0;
    int total;
    int c;
    int n;
    reset_i          = 1'b1;
    dct_valid_i      = 1'b0;
    dct_buffer_i     = '0;
    dct_count_i      = '0;
    test_ending_i    = 1'b0;
    test_has_ended_i = 1'b0;
    out_ready_i      = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(dct_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_frames", 32'(frame_count_o), 32'd0);
    chk("rst_flags", {29'd0, count_err_o, trunc_err_o, done_o}, 32'd0);
    chk("rst_data", {21'd0, out_last_o, out_data_o}, 32'd0);
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    reset_i = 1'b0;

    // Single 3-slot frame: latency and last marker.
    out_ready_i = 1'b1;
    send_frame({10'h2A5, 10'h1C3, 10'h0F1}, 4'd3);
    chk("t1_valid_lat", 32'(out_valid_o), 32'd0);
    chk("t1_state", 32'(state_o), 32'(S_UNLOAD));
    chk("t1_ready_busy", 32'(dct_ready_o), 32'd0);
    tick();
    chk("t1_s0", {21'd0, out_last_o, out_data_o}, {21'd0, 1'b0, 10'h0F1});
    tick();
    chk("t1_s1", {21'd0, out_last_o, out_data_o}, {21'd0, 1'b0, 10'h1C3});
    tick();
    chk("t1_s2", {21'd0, out_last_o, out_data_o}, {21'd0, 1'b1, 10'h2A5});
    chk("t1_ready_back", 32'(dct_ready_o), 32'd1);
    tick();
    chk("t1_empty", 32'(out_valid_o), 32'd0);
    chk("t1_frames", 32'(frame_count_o), 32'd1);

    // Fill past DEPTH with the sink stalled, then full push/pop corner.
    apply_reset();
    p0 = n_pops;
    for (int f = 0; f < 6; f++) send_frame(30'($urandom), 4'd3);
    tick();
    tick();
    tick();
    chk("t2_level_full", 32'(fifo_level_o), 32'd16);
    chk("t2_stall_state", 32'(state_o), 32'(S_UNLOAD));
    chk("t2_ready", 32'(dct_ready_o), 32'd0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("t2_full_pushpop", 32'(fifo_level_o), 32'd15);
    tick();
    chk("t2_refill", 32'(fifo_level_o), 32'd16);
    out_ready_i = 1'b1;
    wait_settle("t2_drain");
    chk("t2_model_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_pops", 32'(n_pops - p0), 32'd18);
    chk("t2_frames", 32'(frame_count_o), 32'd6);

    // count=0 then count>SLOTS.
    apply_reset();
    out_ready_i = 1'b1;
    p0 = n_pops;
    send_frame(30'($urandom), 4'd0);
    chk("t3_zero_state", 32'(state_o), 32'(S_IDLE));
    tick();
    tick();
    chk("t3_zero_level", 32'(fifo_level_o), 32'd0);
    chk("t3_zero_frames", 32'(frame_count_o), 32'd1);
    chk("t3_zero_cerr", 32'(count_err_o), 32'd0);
    send_frame(30'($urandom), 4'd5);
    chk("t3_cerr", 32'(count_err_o), 32'd1);
    wait_settle("t3_drain");
    chk("t3_pops", 32'(n_pops - p0), 32'd3);
    chk("t3_frames", 32'(frame_count_o), 32'd2);

    // Clean drain via test_ending.
    apply_reset();
    send_frame(30'($urandom), 4'd2);
    wait_unload_done("t4_unload");
    chk("t4_level", 32'(fifo_level_o), 32'd2);
    test_ending_i = 1'b1;
    #1;
    chk("t4_ready_drop", 32'(dct_ready_o), 32'd0);
    tick();
    chk("t4_drain_state", 32'(state_o), 32'(S_DRAIN));
    out_ready_i = 1'b1;
    n = 0;
    while (fifo_level_o != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_emptied", 32'(fifo_level_o), 32'd0);
    chk("t4_not_done_yet", 32'(done_o), 32'd0);
    tick();
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_done_state", 32'(state_o), 32'(S_DONE));
    chk("t4_trunc", 32'(trunc_err_o), 32'd0);
    test_ending_i = 1'b0;
    out_ready_i   = 1'b0;
    #1;
    chk("t4_ready_held", 32'(dct_ready_o), 32'd0);

    // Truncation via test_has_ended with data pending.
    apply_reset();
    send_frame(30'($urandom), 4'd3);
    send_frame(30'($urandom), 4'd1);
    wait_unload_done("t5_unload");
    chk("t5_level", 32'(fifo_level_o), 32'd4);
    test_has_ended_i = 1'b1;
    tick();
    test_has_ended_i = 1'b0;
    chk("t5_trunc", 32'(trunc_err_o), 32'd1);
    chk("t5_state", 32'(state_o), 32'(S_DONE));
    out_ready_i = 1'b1;
    wait_settle("t5_readout");
    chk("t5_model_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of an unload.
    apply_reset();
    send_frame(30'($urandom), 4'd5);
    tick();
    chk("t5b_mid_state", 32'(state_o), 32'(S_UNLOAD));
    chk("t5b_mid_cerr", 32'(count_err_o), 32'd1);
    #3;
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    chk("t5b_ready", 32'(dct_ready_o), 32'd1);
    chk("t5b_level", 32'(fifo_level_o), 32'd0);
    chk("t5b_valid", 32'(out_valid_o), 32'd0);
    chk("t5b_state", 32'(state_o), 32'(S_IDLE));
    chk("t5b_frames", 32'(frame_count_o), 32'd0);
    chk("t5b_flags", {29'd0, count_err_o, trunc_err_o, done_o}, 32'd0);
    tick();
    reset_i = 1'b0;

    // Random frames through the FIFO with a random sink, 40+ slots.
    apply_reset();
    p0       = n_pops;
    total    = 0;
    rand_rdy = 1'b1;
    while (total < 40) begin
      c = int'($urandom_range(0, 4));
      send_frame(30'($urandom), 4'(c));
      total += (c > SLOTS) ? SLOTS : c;
    end
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;
    wait_settle("t6_drain");
    chk("t6_model_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_pops", 32'(n_pops - p0), 32'(total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
